// File: rtl/rfphoenix_branch_predictor.sv
// Gshare direction predictor: 2-bit counters indexed by PC ^ GHR, speculative
// global history with mispredict restore, and a one-entry-per-cycle clear sweep.
module rfphoenix_branch_predictor #(
  parameter int unsigned IDXW    = 9,
  parameter int unsigned HIST    = 8,
  parameter int unsigned IDX_LSB = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            ready_o,
  input  logic            pred_req_i,
  input  logic [31:0]     pred_pc_i,
  output logic            pred_vld_o,
  output logic            pred_taken_o,
  output logic [IDXW-1:0] pred_idx_o,
  output logic [HIST-1:0] pred_ghr_o,
  input  logic            upd_i,
  input  logic [IDXW-1:0] upd_idx_i,
  input  logic [HIST-1:0] upd_ghr_i,
  input  logic            upd_taken_i,
  input  logic            upd_mispred_i
);

  localparam int unsigned DEPTH = 1 << IDXW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_init_idx;
  logic [HIST-1:0] r_ghr;
  logic [1:0]      r_tbl [DEPTH];
  logic            r_ready;
  logic            r_pred_vld;
  logic            r_pred_taken;
  logic [IDXW-1:0] r_pred_idx;
  logic [HIST-1:0] r_pred_ghr;

  logic            w_run;
  logic            w_req;
  logic            w_upd;
  logic [IDXW-1:0] w_pred_idx;
  logic [1:0]      w_upd_ctr;
  logic [1:0]      w_upd_new;
  logic            w_we;
  logic [IDXW-1:0] w_waddr;
  logic [1:0]      w_wdata;
  logic            w_unused;

  assign w_unused = ^{pred_pc_i, upd_ghr_i[HIST-1]};

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  // Next-state: leave INIT after the sweep writes the last entry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_idx == IDXW'(DEPTH - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_run      = (r_state == ST_RUN);
  assign w_req      = pred_req_i & w_run;
  assign w_upd      = upd_i & w_run;
  assign w_pred_idx = pred_pc_i[IDX_LSB +: IDXW] ^ IDXW'(r_ghr);

  // Saturating counter update
  always_comb begin
    w_upd_ctr = r_tbl[upd_idx_i];
    w_upd_new = w_upd_ctr;
    if (upd_taken_i) begin
      if (w_upd_ctr != 2'b11) w_upd_new = 2'(w_upd_ctr + 2'd1);
    end else begin
      if (w_upd_ctr != 2'b00) w_upd_new = 2'(w_upd_ctr - 2'd1);
    end
  end

  // Write port: sweep owns it in INIT, resolved updates in RUN
  always_comb begin
    w_we    = 1'b0;
    w_waddr = upd_idx_i;
    w_wdata = w_upd_new;
    if (!w_run) begin
      w_we    = 1'b1;
      w_waddr = r_init_idx;
      w_wdata = 2'b01;
    end else if (w_upd) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_we) r_tbl[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_init_idx   <= '0;
      r_ghr        <= '0;
      r_ready      <= 1'b0;
      r_pred_vld   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
      r_pred_ghr   <= '0;
    end else begin
      r_ready    <= (w_state_nxt == ST_RUN);
      r_pred_vld <= w_req;
      if (!w_run) r_init_idx <= IDXW'(r_init_idx + 1'b1);
      // Read-before-write: the table read sees the pre-update counter
      if (w_req) begin
        r_pred_taken <= r_tbl[w_pred_idx][1];
        r_pred_idx   <= w_pred_idx;
        r_pred_ghr   <= r_ghr;
      end
      // Mispredict restore outranks the speculative shift
      if (w_upd && upd_mispred_i) r_ghr <= {upd_ghr_i[HIST-2:0], upd_taken_i};
      else if (r_pred_vld)        r_ghr <= {r_ghr[HIST-2:0], r_pred_taken};
    end
  end

  assign ready_o      = r_ready;
  assign pred_vld_o   = r_pred_vld;
  assign pred_taken_o = r_pred_taken;
  assign pred_idx_o   = r_pred_idx;
  assign pred_ghr_o   = r_pred_ghr;

endmodule
